pipelined_approx_adder: RTL and testbench

// - Parametrised, segmented, pipelined adder: successor to the fixed 8-bit combinational adders.
// - Adds WIDTH-bit a+b one SEG_WIDTH-bit segment per stage, with a carry register between stages.
// - Lower APPROX_BITS can run as a lower-part-OR approximation, selected per transaction.
// - Valid/ready on both sides, so it drops into streaming datapaths and accuracy-evaluation harnesses.
//

---
 rtl/pipelined_approx_adder.sv | 188 ++++++++++++++++++
 tb/tb_pipelined_approx_adder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_approx_adder.sv
// Segmented pipelined adder: one SEG_WIDTH slice per stage, optional lower-part-OR approximation.
// Define ERROR_MON_EN to add the exact shadow pipe plus the err / err_count outputs.
module pipelined_approx_adder #(
  parameter int WIDTH       = 16,
  parameter int SEG_WIDTH   = 4,
  parameter int APPROX_BITS = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry
`ifdef ERROR_MON_EN
  ,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] err_count
`endif
);

  localparam int STAGES = WIDTH / SEG_WIDTH;

  // One segment of the sum. Bits below APPROX_BITS are OR'd when apx is set; the
  // top approximated bit feeds a&b into the first exact bit, which is what splits a straddling segment.
  function automatic logic [SEG_WIDTH:0] seg_add(
    input logic [SEG_WIDTH-1:0] x,
    input logic [SEG_WIDTH-1:0] y,
    input logic                 cin,
    input logic                 apx,
    input int                   base
  );
    logic                 c;
    logic [SEG_WIDTH-1:0] s;
    c = cin;
    s = '0;
    for (int j = 0; j < SEG_WIDTH; j++) begin
      if (apx && ((base + j) < APPROX_BITS)) begin
        s[j] = x[j] | y[j];
        c    = ((base + j) == (APPROX_BITS - 1)) ? (x[j] & y[j]) : 1'b0;
      end else begin
        s[j] = x[j] ^ y[j] ^ c;
        c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
      end
    end
    return {c, s};
  endfunction

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [STAGES-1:0] r_apx;
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic [STAGES-1:0] r_cy;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_src_v;
  logic [WIDTH-1:0]  w_src_a   [STAGES];
  logic [WIDTH-1:0]  w_src_b   [STAGES];
  logic [STAGES-1:0] w_src_apx;
  logic [WIDTH-1:0]  w_src_sum [STAGES];
  logic [STAGES-1:0] w_src_cy;
  logic [WIDTH-1:0]  w_nxt_sum [STAGES];
  logic [STAGES-1:0] w_nxt_cy;

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // Stage k moves when any stage from k to the end is empty or the output is taken,
  // so in_ready is combinational from out_ready and a full pipe streams with no bubbles.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      logic full;
      full = 1'b1;
      for (int j = k; j < STAGES; j++) full &= r_vld[j];
      w_adv[k] = out_ready | !full;
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_vld[STAGES-1];
  assign out       = r_sum[STAGES-1];
  assign carry     = r_cy[STAGES-1];

  always_comb begin
    w_src_v[0]   = in_valid;
    w_src_a[0]   = a;
    w_src_b[0]   = b;
    w_src_apx[0] = approx_en;
    w_src_sum[0] = '0;
    w_src_cy[0]  = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      w_src_v[k]   = r_vld[k-1];
      w_src_a[k]   = r_a[k-1];
      w_src_b[k]   = r_b[k-1];
      w_src_apx[k] = r_apx[k-1];
      w_src_sum[k] = r_sum[k-1];
      w_src_cy[k]  = r_cy[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      logic [SEG_WIDTH:0] seg;
      seg = seg_add(w_src_a[k][k*SEG_WIDTH +: SEG_WIDTH], w_src_b[k][k*SEG_WIDTH +: SEG_WIDTH],
                    w_src_cy[k], w_src_apx[k], k * SEG_WIDTH);
      w_nxt_sum[k] = w_src_sum[k];
      w_nxt_sum[k][k*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
      w_nxt_cy[k]  = seg[SEG_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_apx <= '0;
      r_cy  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= w_src_v[k];
          r_a[k]   <= w_src_a[k];
          r_b[k]   <= w_src_b[k];
          r_apx[k] <= w_src_apx[k];
          r_sum[k] <= w_nxt_sum[k];
          r_cy[k]  <= w_nxt_cy[k];
        end
      end
    end
  end

`ifdef ERROR_MON_EN
  logic [WIDTH-1:0]  r_esum [STAGES];
  logic [STAGES-1:0] r_ecy;
  logic [WIDTH-1:0]  w_src_esum [STAGES];
  logic [STAGES-1:0] w_src_ecy;
  logic [WIDTH-1:0]  w_nxt_esum [STAGES];
  logic [STAGES-1:0] w_nxt_ecy;

  // Shadow exact sum rides alongside the main sum using the same operand registers.
  always_comb begin
    w_src_esum[0] = '0;
    w_src_ecy[0]  = 1'b0;
    for (int k = 1; k < STAGES; k++) begin
      w_src_esum[k] = r_esum[k-1];
      w_src_ecy[k]  = r_ecy[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      logic [SEG_WIDTH:0] eseg;
      eseg = seg_add(w_src_a[k][k*SEG_WIDTH +: SEG_WIDTH], w_src_b[k][k*SEG_WIDTH +: SEG_WIDTH],
                     w_src_ecy[k], 1'b0, k * SEG_WIDTH);
      w_nxt_esum[k] = w_src_esum[k];
      w_nxt_esum[k][k*SEG_WIDTH +: SEG_WIDTH] = eseg[SEG_WIDTH-1:0];
      w_nxt_ecy[k]  = eseg[SEG_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ecy <= '0;
      for (int k = 0; k < STAGES; k++) r_esum[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_esum[k] <= w_nxt_esum[k];
          r_ecy[k]  <= w_nxt_ecy[k];
        end
      end
    end
  end

  assign err = out_valid && ({carry, out} != {r_ecy[STAGES-1], r_esum[STAGES-1]});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && err && (err_count != {CNT_WIDTH{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Self-checking bench for pipelined_approx_adder (WIDTH=16, SEG_WIDTH=4, APPROX_BITS=4).
// Expected sums come from a plain-arithmetic reference model and a FIFO scoreboard.
module tb_pipelined_approx_adder;

  localparam int W = 16;
  localparam int L = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         carry;
`ifdef ERROR_MON_EN
  logic         err;
  logic [15:0]  err_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0] exp_q[$];
  logic       err_q[$];

  pipelined_approx_adder #(.WIDTH(W), .SEG_WIDTH(4), .APPROX_BITS(L), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry)
`ifdef ERROR_MON_EN
    ,
    .err       (err),
    .err_count (err_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    approx_en = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic apx);
    int unsigned lo, hi, cin;
    if (!apx || L == 0) return {1'b0, x} + {1'b0, y};
    lo  = (int'(x) | int'(y)) & ((1 << L) - 1);
    cin = int'(x[L-1] & y[L-1]);
    hi  = (int'(x) >> L) + (int'(y) >> L) + cin;
    return (W+1)'((hi << L) | lo);
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle's inputs at the falling edge and reports what will transfer at the next rising edge.
  task automatic step(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic apx, input logic ordy,
                      output logic acc, output logic ov, output logic otx,
                      output logic [W:0] res, output logic e);
    @(negedge clk);
    in_valid  = v;
    a         = ia;
    b         = ib;
    approx_en = apx;
    out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    ov  = out_valid;
    otx = out_valid & out_ready;
    res = {carry, out};
`ifdef ERROR_MON_EN
    e = err;
`else
    e = 1'b0;
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out !== 16'h0000) $display("FAIL reset_out got=%h exp=0000", out); else n_pass++;
    n_checks++; if (carry !== 1'b0) $display("FAIL reset_carry got=%b exp=0", carry); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else n_pass++;
`ifdef ERROR_MON_EN
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    n_checks++; if (err_count !== 16'd0) $display("FAIL reset_err_count got=%0d exp=0", err_count); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    logic acc, ov, otx, e;
    logic [W:0] res;
    int lat;
    lat = -1;
    step(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1, acc, ov, otx, res, e);
    n_checks++; if (acc !== 1'b1) $display("FAIL wrap_accept got=%b exp=1", acc); else n_pass++;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, otx, res, e);
      if (otx) begin lat = i; break; end
    end
    n_checks++; if (lat != 4) $display("FAIL wrap_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (res !== 17'h10000) $display("FAIL wrap_sum got=%h exp=10000", res); else n_pass++;
    n_checks++; if (e !== 1'b0) $display("FAIL wrap_err got=%b exp=0", e); else n_pass++;
  endtask

  task automatic test_approx();
    logic [W-1:0] va [2];
    logic [W-1:0] vb [2];
    logic [W:0]   vr [2];
    logic acc, ov, otx, e;
    logic [W:0] res;
    va[0] = 16'h000F; vb[0] = 16'h0001; vr[0] = 17'h0000F;
    va[1] = 16'h0008; vb[1] = 16'h0008; vr[1] = 17'h00018;
    for (int t = 0; t < 2; t++) begin
      bit got;
      got = 0;
      step(1'b1, va[t], vb[t], 1'b1, 1'b1, acc, ov, otx, res, e);
      for (int i = 0; i < 20 && !got; i++) begin
        step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, otx, res, e);
        if (otx) got = 1;
      end
      n_checks++; if (!got) $display("FAIL approx_timeout vec=%0d got=none exp=result", t); else n_pass++;
      n_checks++; if (res !== vr[t]) $display("FAIL approx_sum vec=%0d got=%h exp=%h", t, res, vr[t]); else n_pass++;
      n_checks++; if (res !== model(va[t], vb[t], 1'b1)) $display("FAIL approx_model vec=%0d got=%h exp=%h", t, res, model(va[t], vb[t], 1'b1)); else n_pass++;
`ifdef ERROR_MON_EN
      n_checks++; if (e !== 1'b1) $display("FAIL approx_err vec=%0d got=%b exp=1", t, e); else n_pass++;
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, otx, res, e);
      n_checks++; if (err_count !== 16'(t + 1)) $display("FAIL approx_err_count vec=%0d got=%0d exp=%0d", t, err_count, t + 1); else n_pass++;
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         tp [6];
    logic acc, ov, otx, e;
    logic [W:0] res, exp_v;
    int idx, got, acc_low;
    bit blocked;
    exp_q.delete();
    idx = 0; got = 0; acc_low = 0; blocked = 0;
    for (int i = 0; i < 6; i++) begin
      ta[i] = 16'($urandom); tb[i] = 16'($urandom); tp[i] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c < 60 && got < 6; c++) begin
      logic v, ordy;
      v    = (idx < 6);
      ordy = (c >= 5);
      step(v, v ? ta[idx] : '0, v ? tb[idx] : '0, v ? tp[idx] : 1'b0, ordy, acc, ov, otx, res, e);
      if (c == 4 && v && !acc) blocked = 1;
      if (acc) begin
        exp_q.push_back(model(ta[idx], tb[idx], tp[idx]));
        idx++;
        if (!ordy) acc_low++;
      end
      if (otx) begin
        exp_v = exp_q.pop_front();
        n_checks++; if (res !== exp_v) $display("FAIL b2b_order item=%0d got=%h exp=%h", got, res, exp_v); else n_pass++;
        got++;
      end
    end
    n_checks++; if (acc_low != 4) $display("FAIL b2b_accepts_stalled got=%0d exp=4", acc_low); else n_pass++;
    n_checks++; if (!blocked) $display("FAIL b2b_in_ready_drop got=1 exp=0"); else n_pass++;
    n_checks++; if (got != 6) $display("FAIL b2b_count got=%0d exp=6", got); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL b2b_leftover got=%0d exp=0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    logic acc, ov, otx, e;
    logic [W:0] res;
    int stray, lat;
    stray = 0; lat = -1;
    for (int i = 0; i < 4; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, acc, ov, otx, res, e);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b1) $display("FAIL midrst_pre_valid got=%b exp=1", out_valid); else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_valid_drop got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out !== 16'h0000) $display("FAIL midrst_out got=%h exp=0000", out); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, otx, res, e);
      if (ov) stray++;
    end
    n_checks++; if (stray != 0) $display("FAIL midrst_stray got=%0d exp=0", stray); else n_pass++;
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, acc, ov, otx, res, e);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, '0, '0, 1'b0, 1'b1, acc, ov, otx, res, e);
      if (otx) begin lat = i; break; end
    end
    n_checks++; if (lat != 4) $display("FAIL midrst_new_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (res !== 17'h05555) $display("FAIL midrst_new_sum got=%h exp=05555", res); else n_pass++;
  endtask

  task automatic test_random();
    logic acc, ov, otx, e;
    logic [W:0] res, exp_v, prev_res;
    logic exp_e, hold;
    int sent, bad, exp_cnt;
    apply_reset();
    exp_q.delete();
    err_q.delete();
    sent = 0; exp_cnt = 0; hold = 0; prev_res = '0;
    for (int c = 0; c < 12000 && (sent < 2000 || exp_q.size() != 0); c++) begin
      logic v, apx, ordy;
      logic [W-1:0] ra, rb;
      v    = (sent < 2000) && ($urandom_range(0, 9) < 8);
      apx  = 1'($urandom_range(0, 1));
      ordy = (sent >= 2000) || ($urandom_range(0, 9) < 7);
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      step(v, ra, rb, apx, ordy, acc, ov, otx, res, e);
      if (hold) begin
        n_checks++;
        if (!ov || res !== prev_res) $display("FAIL rand_stall_stable got=%b/%h exp=1/%h", ov, res, prev_res);
        else n_pass++;
      end
      hold     = ov && !ordy;
      prev_res = res;
      if (acc) begin
        exp_q.push_back(model(ra, rb, apx));
        err_q.push_back(model(ra, rb, apx) != ({1'b0, ra} + {1'b0, rb}));
        sent++;
      end
      if (otx) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_unexpected got=%h exp=none", res);
        end else begin
          exp_v = exp_q.pop_front();
          exp_e = err_q.pop_front();
          bad = (res !== exp_v);
`ifdef ERROR_MON_EN
          if (e !== exp_e) bad = 1;
          if (exp_e) exp_cnt++;
`endif
          if (bad) $display("FAIL rand_result got=%h/%b exp=%h/%b", res, e, exp_v, exp_e);
          else n_pass++;
        end
      end
    end
    n_checks++; if (sent != 2000) $display("FAIL rand_sent got=%0d exp=2000", sent); else n_pass++;
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain got=%0d exp=0", exp_q.size()); else n_pass++;
`ifdef ERROR_MON_EN
    @(negedge clk);
    n_checks++; if (err_count !== 16'(exp_cnt)) $display("FAIL rand_err_count got=%0d exp=%0d", err_count, exp_cnt); else n_pass++;
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_wrap();
    test_approx();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
